// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the priority encoder: FSM states, default
// request count and the code-width calculation.
package priority_encoder_pkg;

  localparam int N_REQ_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/priority_encoder_if.sv
// Request/grant bundle between a request source (master) and the encoder (slave).
interface priority_encoder_if #(
  parameter int N_REQ  = priority_encoder_pkg::N_REQ_DEFAULT,
  parameter int CODE_W = priority_encoder_pkg::clog2(N_REQ)
);

  logic [N_REQ-1:0]  req;
  logic              ack;
  logic [CODE_W-1:0] code;
  logic [N_REQ-1:0]  onehot;
  logic              valid;
  logic [N_REQ-1:0]  pending;
  logic              overrun;

  modport master (
    output req,
    output ack,
    input  code,
    input  onehot,
    input  valid,
    input  pending,
    input  overrun
  );

  modport slave (
    input  req,
    input  ack,
    output code,
    output onehot,
    output valid,
    output pending,
    output overrun
  );

endinterface

// File: rtl/priority_encoder_find_first.sv
// Combinational first-set-bit finder; MSB_FIRST selects which end of the
// vector has priority.
module pe_find_first #(
  parameter int N_REQ     = priority_encoder_pkg::N_REQ_DEFAULT,
  parameter int CODE_W    = priority_encoder_pkg::clog2(N_REQ),
  parameter int MSB_FIRST = 1
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Scan toward the winning end so the last hit seen is the one that wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) begin
          idx = i[CODE_W-1:0];
          any = 1'b1;
        end
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = i[CODE_W-1:0];
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Captures rising edges on request lines as pending bits and hands them out
// one at a time, highest priority first, over a valid/ack handshake.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int CODE_W    = clog2(N_REQ),
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  priority_encoder_if.slave  bus
);

  logic [N_REQ-1:0]  req_q, req_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [N_REQ-1:0]  onehot_q, onehot_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  state_e            state_q, state_d;

  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  grant_onehot;
  logic [CODE_W-1:0] find_idx;
  logic              find_any;
  logic              load;

  // Priority is taken from registered pending only, so a rise this cycle
  // cannot be granted before the next one.
  pe_find_first #(
    .N_REQ     (N_REQ),
    .CODE_W    (CODE_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_find (
    .vec (pending_q),
    .idx (find_idx),
    .any (find_any)
  );

  always_comb begin
    grant_onehot = '0;
    grant_onehot[find_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (find_any) begin
          load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.ack) begin
          if (find_any) begin
            load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            code_d   = '0;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d  = ST_HOLD;
      valid_d  = 1'b1;
      code_d   = find_idx;
      onehot_d = grant_onehot;
    end
  end

  // A new rise on a bit being granted this cycle re-arms it rather than being lost.
  always_comb begin
    req_d     = bus.req;
    rise      = bus.req & ~req_q;
    clr       = load ? grant_onehot : '0;
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = |(rise & pending_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      pending_q <= '0;
      code_q    <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      req_q     <= req_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign bus.code    = code_q;
  assign bus.onehot  = onehot_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed bench for priority_encoder: an MSB-first instance checked throughout
// and an LSB-first twin sharing its stimulus for the grant-order scenario.
module tb_priority_encoder;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  priority_encoder_if #(.N_REQ(8), .CODE_W(3)) bus ();
  priority_encoder_if #(.N_REQ(8), .CODE_W(3)) bus_l ();

  assign bus_l.req = bus.req;
  assign bus_l.ack = bus.ack;

  priority_encoder #(.N_REQ(8), .CODE_W(3), .MSB_FIRST(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  priority_encoder #(.N_REQ(8), .CODE_W(3), .MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    bus.ack = 1'b0;
    tick();
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.code !== 3'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", bus.code); end
    checks++; if (bus.onehot !== 8'h00) begin errors++; $display("[TB] FAIL reset_onehot: got %h expected 00", bus.onehot); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 00", bus.pending); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_grant();
    bus.req = 8'h20;
    tick();
    checks++; if (bus.pending !== 8'h20) begin errors++; $display("[TB] FAIL single_pending1: got %h expected 20", bus.pending); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid1: got %b expected 0", bus.valid); end
    tick();
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid2: got %b expected 1", bus.valid); end
    checks++; if (bus.code !== 3'd5) begin errors++; $display("[TB] FAIL single_code: got %0d expected 5", bus.code); end
    checks++; if (bus.onehot !== 8'h20) begin errors++; $display("[TB] FAIL single_onehot: got %h expected 20", bus.onehot); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("[TB] FAIL single_pending2: got %h expected 00", bus.pending); end
    tick();
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd5) begin errors++; $display("[TB] FAIL single_hold: got valid=%b code=%0d expected valid=1 code=5", bus.valid, bus.code); end
    bus.ack = 1'b1;
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got %b expected 0", bus.valid); end
    checks++; if (bus.onehot !== 8'h00) begin errors++; $display("[TB] FAIL single_onehot_off: got %h expected 00", bus.onehot); end
    bus.ack = 1'b0;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_msb [3];
    logic [2:0] exp_lsb [3];
    exp_msb = '{3'd7, 3'd4, 3'd0};
    exp_lsb = '{3'd0, 3'd4, 3'd7};
    bus.req = 8'h91;
    bus.ack = 1'b1;
    tick();
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h91) begin errors++; $display("[TB] FAIL b2b_capture: got valid=%b pending=%h expected valid=0 pending=91", bus.valid, bus.pending); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.valid !== 1'b1 || bus.code !== exp_msb[i]) begin errors++; $display("[TB] FAIL b2b_msb_grant%0d: got valid=%b code=%0d expected valid=1 code=%0d", i, bus.valid, bus.code, exp_msb[i]); end
      checks++; if (bus_l.valid !== 1'b1 || bus_l.code !== exp_lsb[i]) begin errors++; $display("[TB] FAIL b2b_lsb_grant%0d: got valid=%b code=%0d expected valid=1 code=%0d", i, bus_l.valid, bus_l.code, exp_lsb[i]); end
    end
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_msb_done: got %b expected 0", bus.valid); end
    checks++; if (bus_l.valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_lsb_done: got %b expected 0", bus_l.valid); end
    bus.ack = 1'b0;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_overrun();
    bus.req = 8'h48;
    tick();
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd6 || bus.pending !== 8'h08) begin errors++; $display("[TB] FAIL ovr_setup: got valid=%b code=%0d pending=%h expected 1/6/08", bus.valid, bus.code, bus.pending); end
    bus.req = 8'h40;
    tick();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_quiet: got %b expected 0", bus.overrun); end
    bus.req = 8'h48;
    tick();
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_pulse: got %b expected 1", bus.overrun); end
    checks++; if (bus.pending !== 8'h08 || bus.code !== 3'd6) begin errors++; $display("[TB] FAIL ovr_state: got pending=%h code=%0d expected 08/6", bus.pending, bus.code); end
    tick();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_one_cycle: got %b expected 0", bus.overrun); end
    bus.ack = 1'b1;
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd3 || bus.pending !== 8'h00) begin errors++; $display("[TB] FAIL ovr_grant3: got valid=%b code=%0d pending=%h expected 1/3/00", bus.valid, bus.code, bus.pending); end
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_single_grant: got %b expected 0", bus.valid); end
    bus.ack = 1'b0;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_set_wins();
    bus.req = 8'h24;
    tick();
    tick();
    checks++; if (bus.code !== 3'd5 || bus.pending !== 8'h04) begin errors++; $display("[TB] FAIL setw_setup: got code=%0d pending=%h expected 5/04", bus.code, bus.pending); end
    bus.req = 8'h20;
    tick();
    bus.req = 8'h24;
    bus.ack = 1'b1;
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd2) begin errors++; $display("[TB] FAIL setw_grant1: got valid=%b code=%0d expected 1/2", bus.valid, bus.code); end
    checks++; if (bus.pending !== 8'h04) begin errors++; $display("[TB] FAIL setw_pending: got %h expected 04", bus.pending); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL setw_overrun: got %b expected 0", bus.overrun); end
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd2 || bus.pending !== 8'h00) begin errors++; $display("[TB] FAIL setw_grant2: got valid=%b code=%0d pending=%h expected 1/2/00", bus.valid, bus.code, bus.pending); end
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL setw_done: got %b expected 0", bus.valid); end
    bus.ack = 1'b0;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_held_through_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    tick();
    tick();
    rst_n   = 1'b1;
    bus.ack = 1'b1;
    tick();
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'hFF) begin errors++; $display("[TB] FAIL held_capture: got valid=%b pending=%h expected 0/FF", bus.valid, bus.pending); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.valid !== 1'b1 || bus.code !== 3'(7 - i)) begin errors++; $display("[TB] FAIL held_grant%0d: got valid=%b code=%0d expected 1/%0d", i, bus.valid, bus.code, 7 - i); end
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL held_overrun%0d: got %b expected 0", i, bus.overrun); end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("[TB] FAIL held_no_repeat%0d: got valid=%b pending=%h expected 0/00", i, bus.valid, bus.pending); end
    end
    bus.ack = 1'b0;
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.req = 8'h1C;
    tick();
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd4 || bus.pending !== 8'h0C) begin errors++; $display("[TB] FAIL midrst_setup: got valid=%b code=%0d pending=%h expected 1/4/0C", bus.valid, bus.code, bus.pending); end
    rst_n   = 1'b0;
    bus.req = 8'h00;
    tick();
    checks++; if (bus.valid !== 1'b0 || bus.code !== 3'd0 || bus.onehot !== 8'h00 || bus.pending !== 8'h00 || bus.overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got valid=%b code=%0d onehot=%h pending=%h overrun=%b expected all 0", bus.valid, bus.code, bus.onehot, bus.pending, bus.overrun);
    end
    rst_n   = 1'b1;
    bus.ack = 1'b1;
    tick();
    tick();
    checks++; if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin errors++; $display("[TB] FAIL midrst_idle_ack: got valid=%b pending=%h expected 0/00", bus.valid, bus.pending); end
    bus.ack = 1'b0;
    bus.req = 8'h02;
    tick();
    tick();
    checks++; if (bus.valid !== 1'b1 || bus.code !== 3'd1 || bus.onehot !== 8'h02) begin errors++; $display("[TB] FAIL midrst_regrant: got valid=%b code=%0d onehot=%h expected 1/1/02", bus.valid, bus.code, bus.onehot); end
    bus.req = 8'h00;
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    bus.req = 8'h00;
    bus.ack = 1'b0;
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_overrun();
    test_set_wins();
    test_held_through_reset();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
